// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder slice.
//   rd_state_e     : read FSM states (IDLE=0, WAIT=1, RESP=2)
//   DATA_W/STRB_W  : data word width and byte-strobe width
//   ADDR_W         : byte address width
//   addr_in_range  : true when no address bit above the word index is set
package dmem_pkg;

    localparam int DATA_W = 64;
    localparam int STRB_W = 8;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rd_state_e;

    // Word index occupies addr[depth_log2+1:2]; anything above it must be zero.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned depth_log2);
        return (addr >> (depth_log2 + 2)) == '0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Backing storage for dmem_responder.
//   clk      : write clock
//   wr_en    : per-byte write enables (bit i -> byte lane i)
//   wr_idx   : word index of the write
//   wr_data  : write data
//   rd_idx   : word index of the asynchronous read
//   rd_data  : current contents of word rd_idx
// Storage has no reset; contents survive rst_n.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 7
) (
    input  logic                  clk,
    input  logic [STRB_W-1:0]     wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < STRB_W; i++) begin
            if (wr_en[i]) begin
                mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the dcache miss / write-back interface.
//   clk, rst_n    : single clock, asynchronous active-low reset
//   mrden         : one-cycle read request
//   m_rd_address  : read byte address
//   mwren         : byte strobes of a write (0 = no write)
//   m_wr_address  : write byte address
//   data2mem      : write data
//   data_in_mem   : read data, held until the next response
//   rd_valid      : high during the response cycle
//   busy          : a read is outstanding
//   addr_err      : sticky out-of-range access / dropped read flag
// A read accepted at edge N is answered in the cycle after edge N+RD_LATENCY;
// data_in_mem samples the array at the edge that ends that cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 7,
    parameter int RD_LATENCY = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mrden,
    input  logic [ADDR_W-1:0] m_rd_address,
    input  logic [STRB_W-1:0] mwren,
    input  logic [ADDR_W-1:0] m_wr_address,
    input  logic [DATA_W-1:0] data2mem,
    output logic [DATA_W-1:0] data_in_mem,
    output logic              rd_valid,
    output logic              busy,
    output logic              addr_err
);

    localparam int CNT_W = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((RD_LATENCY < 1) ? 0 : RD_LATENCY - 1);

    rd_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  inr_q, inr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  err_q, err_d;

    logic                  rd_inr, wr_inr;
    logic [STRB_W-1:0]     arr_wr_en;
    logic [DATA_W-1:0]     arr_rd_data;
    logic                  unused_addr_bits;

    assign rd_inr = addr_in_range(m_rd_address, DEPTH_LOG2);
    assign wr_inr = addr_in_range(m_wr_address, DEPTH_LOG2);
    assign unused_addr_bits = ^{m_rd_address[1:0], m_wr_address[1:0]};

    // Writes are suppressed while reset is held so nothing lands during reset.
    assign arr_wr_en = (rst_n && wr_inr) ? mwren : '0;

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_idx  (m_wr_address[DEPTH_LOG2+1:2]),
        .wr_data (data2mem),
        .rd_idx  (idx_q),
        .rd_data (arr_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            inr_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            inr_q   <= inr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        inr_d   = inr_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (mrden) begin
                    idx_d = m_rd_address[DEPTH_LOG2+1:2];
                    inr_d = rd_inr;
                    cnt_d = '0;
                    if (!rd_inr) begin
                        err_d = 1'b1;
                    end
                    if (RD_LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                data_d  = inr_q ? arr_rd_data : '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (mrden && (state_q != IDLE)) begin
            err_d = 1'b1;
        end
        if ((mwren != '0) && !wr_inr) begin
            err_d = 1'b1;
        end
    end

    assign data_in_mem = data_q;
    assign rd_valid    = (state_q == RESP);
    assign busy        = (state_q != IDLE);
    assign addr_err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mrden = 1'b0;
    logic [31:0] m_rd_address = '0;
    logic [7:0]  mwren = '0;
    logic [31:0] m_wr_address = '0;
    logic [63:0] data2mem = '0;

    // index 0: RD_LATENCY=10 build, index 1: RD_LATENCY=0 build
    logic [63:0] dout [2];
    logic        rdv  [2];
    logic        bsy  [2];
    logic        aerr [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(7), .RD_LATENCY(10)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .mrden(mrden), .m_rd_address(m_rd_address),
        .mwren(mwren), .m_wr_address(m_wr_address), .data2mem(data2mem),
        .data_in_mem(dout[0]), .rd_valid(rdv[0]), .busy(bsy[0]), .addr_err(aerr[0])
    );

    dmem_responder #(.DEPTH_LOG2(7), .RD_LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mrden(mrden), .m_rd_address(m_rd_address),
        .mwren(mwren), .m_wr_address(m_wr_address), .data2mem(data2mem),
        .data_in_mem(dout[1]), .rd_valid(rdv[1]), .busy(bsy[1]), .addr_err(aerr[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A read is a timestamped transaction: accepted at edge A, it is
    // answered at edge A+lat+1 using the memory contents seen before that edge.
    logic [63:0] mmem [128];
    int          edge_cnt = 0;
    bit          pend [2] = '{0, 0};
    int          due  [2] = '{0, 0};
    int          ridx [2] = '{0, 0};
    bit          rinr [2] = '{0, 0};
    logic [63:0] edata[2] = '{64'h0, 64'h0};
    bit          eerr [2] = '{0, 0};

    function automatic int lat(input int d);
        return (d == 0) ? 10 : 0;
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return a < 32'd512;
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) mmem[i] = '0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt = 0;
            for (int d = 0; d < 2; d++) begin
                pend[d] = 0; edata[d] = '0; eerr[d] = 0;
            end
        end else begin
            edge_cnt = edge_cnt + 1;
            for (int d = 0; d < 2; d++) begin
                bit was_busy;
                was_busy = pend[d];
                if (was_busy && edge_cnt == due[d]) begin
                    edata[d] = rinr[d] ? mmem[ridx[d]] : 64'h0;
                    pend[d] = 0;
                end
                if (mrden) begin
                    if (was_busy) eerr[d] = 1;
                    else begin
                        pend[d] = 1;
                        due[d]  = edge_cnt + lat(d) + 1;
                        ridx[d] = int'(m_rd_address[8:2]);
                        rinr[d] = in_rng(m_rd_address);
                        if (!rinr[d]) eerr[d] = 1;
                    end
                end
                if (mwren != 0 && !in_rng(m_wr_address)) eerr[d] = 1;
            end
            if (mwren != 0 && in_rng(m_wr_address)) begin
                for (int b = 0; b < 8; b++)
                    if (mwren[b]) mmem[m_wr_address[8:2]][8*b +: 8] = data2mem[8*b +: 8];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit erv;
            erv = pend[d] && (edge_cnt == due[d] - 1);
            chk($sformatf("rd_valid[%0d]", d), {63'b0, rdv[d]}, {63'b0, erv});
            chk($sformatf("busy[%0d]", d), {63'b0, bsy[d]}, {63'b0, pend[d]});
            chk($sformatf("addr_err[%0d]", d), {63'b0, aerr[d]}, {63'b0, eerr[d]});
            chk($sformatf("data_in_mem[%0d]", d), dout[d], edata[d]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] dat, input logic [7:0] s);
        m_wr_address = a; data2mem = dat; mwren = s;
        cyc();
        mwren = '0;
    endtask

    task automatic rd(input logic [31:0] a);
        m_rd_address = a; mrden = 1'b1;
        cyc();
        mrden = 1'b0;
    endtask

    task automatic wait_rv(input int d, output int n);
        bit found;
        found = 0;
        n = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            n++;
            if (rdv[d] === 1'b1) found = 1;
        end
        if (!found) chk("rd_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic count_rv(input int d, input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (rdv[d] === 1'b1) cnt++;
        end
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom_range(15) << 2) | $urandom_range(3);
        if ($urandom_range(15) == 0) a[$urandom_range(31, 9)] = 1'b1;
        return a;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        int cnt;

        // Reset held with activity on the inputs: nothing may be accepted.
        m_rd_address = 32'h10; m_wr_address = 32'h10;
        data2mem = 64'hA5A5_A5A5_A5A5_A5A5; mrden = 1'b1; mwren = 8'hFF;
        repeat (4) @(negedge clk);
        chk("reset_busy", {63'b0, bsy[0]}, 64'd0);
        chk("reset_data", dout[0], 64'd0);
        mrden = 1'b0; mwren = '0;
        cyc();
        rst_n = 1'b1;
        cyc();
        rd(32'h10);
        wait_rv(0, n);
        @(negedge clk);
        chk("reset_no_write", dout[0], 64'd0);
        cyc();

        // Write then read, full strobes.
        wr(32'h10, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        rd(32'h10);
        wait_rv(0, n);
        chk("latency10", 64'(n), 64'd11);
        @(negedge clk);
        chk("wr_rd_data", dout[0], 64'hDEAD_BEEF_0123_4567);
        repeat (3) @(negedge clk);
        chk("wr_rd_held", dout[0], 64'hDEAD_BEEF_0123_4567);
        cyc();

        // Byte strobes.
        wr(32'h44, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr(32'h44, 64'h0, 8'h0F);
        rd(32'h44);
        wait_rv(0, n);
        @(negedge clk);
        chk("byte_strobe", dout[0], 64'hFFFF_FFFF_0000_0000);
        cyc();

        // Write landing in the middle of an outstanding read.
        rd(32'h20);
        cyc(); cyc();
        wr(32'h20, 64'h55, 8'hFF);
        wait_rv(0, n);
        @(negedge clk);
        chk("mid_read_write", dout[0], 64'h55);
        cyc();

        // Read while busy is dropped; first read still completes.
        wr(32'h30, 64'h1111_2222_3333_4444, 8'hFF);
        reset_pulse();
        rd(32'h30);
        cyc();
        rd(32'h40);
        @(negedge clk);
        chk("drop_err", {63'b0, aerr[0]}, 64'd1);
        wait_rv(0, n);
        @(negedge clk);
        chk("drop_first_data", dout[0], 64'h1111_2222_3333_4444);
        count_rv(0, 15, cnt);
        chk("drop_no_second", 64'(cnt), 64'd0);
        cyc();

        // Out-of-range read.
        reset_pulse();
        rd(32'h8000_0000);
        wait_rv(0, n);
        @(negedge clk);
        chk("oor_data", dout[0], 64'd0);
        chk("oor_err", {63'b0, aerr[0]}, 64'd1);
        cyc();

        // Zero-latency build answers in the next cycle.
        reset_pulse();
        rd(32'h10);
        wait_rv(1, n);
        chk("latency0", 64'(n), 64'd1);
        @(negedge clk);
        chk("latency0_data", dout[1], 64'hDEAD_BEEF_0123_4567);
        repeat (12) cyc();

        // Reset during WAIT discards the read.
        rd(32'h10);
        repeat (3) cyc();
        reset_pulse();
        count_rv(0, 15, cnt);
        chk("rst_mid_no_rv", 64'(cnt), 64'd0);
        chk("rst_mid_busy", {63'b0, bsy[0]}, 64'd0);
        cyc();

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            mrden        = ($urandom_range(3) == 0);
            m_rd_address = rand_addr();
            m_wr_address = rand_addr();
            data2mem     = {$urandom, $urandom};
            mwren        = ($urandom_range(1) == 1) ? 8'($urandom_range(255)) : 8'h00;
            if ($urandom_range(199) == 0) begin
                mrden = 1'b0; mwren = '0;
                reset_pulse();
            end else begin
                cyc();
            end
        end
        mrden = 1'b0; mwren = '0;
        repeat (15) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
